// File: rtl/add_station_if.sv
`default_nettype none
// ============================================================================
// Module      : add_station_if
// Description : Bundle of the dispatch handshake and result buses around the
//               ADD reservation station.
//               master : dispatcher / environment side (drives issue + buses)
//               slave  : the station itself
//   issue_valid      dispatcher presents an ADD this cycle
//   issue_q1/q2      source tags, 8'h00 = matching value already valid
//   issue_v1/v2      source values (meaningful only when tag is 0)
//   issue_ready      at least one station entry is free
//   issue_tag        tag the next accepted issue receives, 8'h00 when full
//   loadbus/multbus  {tag[39:32], data[31:0]} result buses, tag 0 = idle
//   addbus           registered {tag, value} broadcast of this station
// Revision    : 1.0 - initial release
// ============================================================================
interface add_station_if;
  logic        issue_valid;
  logic [7:0]  issue_q1;
  logic [7:0]  issue_q2;
  logic [31:0] issue_v1;
  logic [31:0] issue_v2;
  logic        issue_ready;
  logic [7:0]  issue_tag;
  logic [39:0] loadbus;
  logic [39:0] multbus;
  logic [39:0] addbus;

  modport master (
    output issue_valid, issue_q1, issue_q2, issue_v1, issue_v2,
    output loadbus, multbus,
    input  issue_ready, issue_tag, addbus
  );

  modport slave (
    input  issue_valid, issue_q1, issue_q2, issue_v1, issue_v2,
    input  loadbus, multbus,
    output issue_ready, issue_tag, addbus
  );
endinterface
`default_nettype wire

// File: rtl/add_station.sv
`default_nettype none
// ============================================================================
// Module      : add_station
// Description : Reservation station and two-stage adder for the ADD unit.
//               Holds dispatched ADDs until both operands are valid, selects
//               the lowest-index ready entry each cycle, adds in an execute
//               register and broadcasts {tag, value} on addbus one edge later.
//               Operands are snooped from addbus, multbus and loadbus.
// Ports       : clk  - clock, all state on the rising edge
//               rst  - asynchronous active-high reset
//               bus  - add_station_if.slave (issue handshake + result buses)
// Parameters  : TAG_BASE - tag of entry 0; entry i uses TAG_BASE+i
//               ENTRIES  - number of station entries (1..8)
// Revision    : 1.0 - initial release
// ============================================================================
module add_station #(
  parameter logic [7:0] TAG_BASE = 8'h20,
  parameter int         ENTRIES  = 3
) (
  input wire           clk,
  input wire           rst,
  add_station_if.slave bus
);

  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] r_busy;
  logic [ENTRIES-1:0] r_inflight;
  logic [7:0]         r_q1 [ENTRIES];
  logic [7:0]         r_q2 [ENTRIES];
  logic [31:0]        r_v1 [ENTRIES];
  logic [31:0]        r_v2 [ENTRIES];

  // Execute stage and broadcast register
  logic               r_ex_valid;
  logic [IDXW-1:0]    r_ex_idx;
  logic [7:0]         r_ex_tag;
  logic [31:0]        r_ex_val;
  logic [39:0]        r_addbus;

  // --------------------------------------------------------------------------
  // Operand snoop: a pending tag is replaced by the data of whichever result
  // bus carries it. Tags are unique so only one bus can match; the fixed
  // priority merely keeps the outcome defined if that is ever violated.
  // Bus tag 0 means idle and can never match since only nonzero q is looked up.
  // --------------------------------------------------------------------------
  function automatic logic [39:0] snoop(
    input logic [7:0]  q,
    input logic [31:0] v,
    input logic [39:0] ab,
    input logic [39:0] mb,
    input logic [39:0] lb
  );
    logic [39:0] res;
    res = {q, v};
    if (q != 8'h00) begin
      if (ab[39:32] == q) begin
        res = {8'h00, ab[31:0]};
      end else if (mb[39:32] == q) begin
        res = {8'h00, mb[31:0]};
      end else if (lb[39:32] == q) begin
        res = {8'h00, lb[31:0]};
      end
    end
    return res;
  endfunction

  // Snooped next values for each held entry
  logic [39:0] w_snp1 [ENTRIES];
  logic [39:0] w_snp2 [ENTRIES];

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_snp1[i] = snoop(r_q1[i], r_v1[i], r_addbus, bus.multbus, bus.loadbus);
      w_snp2[i] = snoop(r_q2[i], r_v2[i], r_addbus, bus.multbus, bus.loadbus);
    end
  end

  // The operands being accepted see the same buses, so a producer that
  // broadcasts in the accept cycle is not missed.
  logic [39:0] w_iss1;
  logic [39:0] w_iss2;

  always_comb begin
    w_iss1 = snoop(bus.issue_q1, bus.issue_v1, r_addbus, bus.multbus, bus.loadbus);
    w_iss2 = snoop(bus.issue_q2, bus.issue_v2, r_addbus, bus.multbus, bus.loadbus);
  end

  // --------------------------------------------------------------------------
  // Ready vector: an entry may be selected once both operands are present and
  // it is not already in the execute stage.
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] w_ready;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_ready
      assign w_ready[gi] = r_busy[gi] && !r_inflight[gi] &&
                           (r_q1[gi] == 8'h00) && (r_q2[gi] == 8'h00);
    end
  endgenerate

  // Lowest-index free entry (accept target) and lowest-index ready entry
  // (select target). Scanning downward lets the lowest index win.
  logic            w_free_any;
  logic [IDXW-1:0] w_free_idx;
  logic            w_sel_any;
  logic [IDXW-1:0] w_sel_idx;

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    w_sel_any  = 1'b0;
    w_sel_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDXW'(i);
      end
      if (w_ready[i]) begin
        w_sel_any = 1'b1;
        w_sel_idx = IDXW'(i);
      end
    end
  end

  logic w_accept;
  assign w_accept = bus.issue_valid && w_free_any;

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy     <= '0;
      r_inflight <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_q1[i] <= 8'h00;
        r_q2[i] <= 8'h00;
        r_v1[i] <= 32'h0;
        r_v2[i] <= 32'h0;
      end
      r_ex_valid <= 1'b0;
      r_ex_idx   <= '0;
      r_ex_tag   <= 8'h00;
      r_ex_val   <= 32'h0;
      r_addbus   <= 40'h0;
    end else begin
      // Broadcast stage: an empty execute stage drives an idle bus.
      r_addbus <= r_ex_valid ? {r_ex_tag, r_ex_val} : 40'h0;

      // Execute stage: carry is discarded, sum wraps modulo 2^32.
      r_ex_valid <= w_sel_any;
      if (w_sel_any) begin
        r_ex_idx <= w_sel_idx;
        r_ex_tag <= TAG_BASE + 8'(w_sel_idx);
        r_ex_val <= r_v1[w_sel_idx] + r_v2[w_sel_idx];
      end

      // Operand capture for entries still waiting.
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_busy[i]) begin
          r_q1[i] <= w_snp1[i][39:32];
          r_v1[i] <= w_snp1[i][31:0];
          r_q2[i] <= w_snp2[i][39:32];
          r_v2[i] <= w_snp2[i][31:0];
        end
      end

      // The entry whose result is being broadcast retires on this edge.
      // It is busy, so it can never be the accept target of the same edge,
      // and it is in flight, so it can never be the select target either.
      if (r_ex_valid) begin
        r_busy[r_ex_idx]     <= 1'b0;
        r_inflight[r_ex_idx] <= 1'b0;
      end

      if (w_sel_any) begin
        r_inflight[w_sel_idx] <= 1'b1;
      end

      // Accept into the lowest free entry; a request while full is dropped
      // and must be held by the dispatcher.
      if (w_accept) begin
        r_busy[w_free_idx]     <= 1'b1;
        r_inflight[w_free_idx] <= 1'b0;
        r_q1[w_free_idx]       <= w_iss1[39:32];
        r_v1[w_free_idx]       <= w_iss1[31:0];
        r_q2[w_free_idx]       <= w_iss2[39:32];
        r_v2[w_free_idx]       <= w_iss2[31:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.issue_ready = w_free_any;
  assign bus.issue_tag   = w_free_any ? (TAG_BASE + 8'(w_free_idx)) : 8'h00;
  assign bus.addbus      = r_addbus;

endmodule
`default_nettype wire

// File: tb/tb_add_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_station
// Description : Self-checking bench for add_station. A behavioural model
//               tracks station entries and a timeline of expected broadcasts;
//               a compare process checks addbus/issue_ready/issue_tag every
//               cycle, and directed scenarios add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_station;

  localparam logic [7:0] TAG_BASE = 8'h20;
  localparam int         ENTRIES  = 3;

  logic clk;
  logic rst;

  add_station_if bus_if ();

  add_station #(
    .TAG_BASE (TAG_BASE),
    .ENTRIES  (ENTRIES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int errors;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: entries as records, results as a timeline indexed by
  // edge number. An op becomes eligible once both operands are known; the
  // lowest eligible entry is scheduled each edge and its {tag,sum} is due on
  // the bus after the following edge, which also frees the entry.
  // --------------------------------------------------------------------------
  typedef struct {
    bit          busy;
    bit          sched;
    logic [7:0]  q1;
    logic [7:0]  q2;
    logic [31:0] v1;
    logic [31:0] v2;
  } slot_t;

  slot_t       m [ENTRIES];
  logic [39:0] m_due [int];
  logic [39:0] m_addbus;
  int          m_edge;

  function automatic void capture(inout logic [7:0] q, inout logic [31:0] v,
                                  input logic [39:0] ab, input logic [39:0] mb,
                                  input logic [39:0] lb);
    if (q == 8'h00) return;
    if (ab[39:32] == q)      begin v = ab[31:0]; q = 8'h00; end
    else if (mb[39:32] == q) begin v = mb[31:0]; q = 8'h00; end
    else if (lb[39:32] == q) begin v = lb[31:0]; q = 8'h00; end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m[i].busy = 0; m[i].sched = 0;
      m[i].q1 = 0; m[i].q2 = 0; m[i].v1 = 0; m[i].v2 = 0;
    end
    m_due.delete();
    m_addbus = 40'h0;
    m_edge   = 0;
  endtask

  task automatic model_edge();
    slot_t       nx [ENTRIES];
    logic [39:0] bc;
    bit          done;
    for (int i = 0; i < ENTRIES; i++) nx[i] = m[i];
    m_edge++;
    bc = 40'h0;
    if (m_due.exists(m_edge)) begin
      bc = m_due[m_edge];
      m_due.delete(m_edge);
      for (int i = 0; i < ENTRIES; i++)
        if (bc[39:32] == TAG_BASE + 8'(i)) begin nx[i].busy = 0; nx[i].sched = 0; end
    end
    done = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!done && m[i].busy && !m[i].sched && m[i].q1 == 0 && m[i].q2 == 0) begin
        nx[i].sched = 1;
        m_due[m_edge + 1] = {TAG_BASE + 8'(i), m[i].v1 + m[i].v2};
        done = 1;
      end
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (m[i].busy) begin
        capture(nx[i].q1, nx[i].v1, m_addbus, bus_if.multbus, bus_if.loadbus);
        capture(nx[i].q2, nx[i].v2, m_addbus, bus_if.multbus, bus_if.loadbus);
      end
    end
    if (bus_if.issue_valid) begin
      done = 0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (!done && !m[i].busy) begin
          nx[i].busy = 1; nx[i].sched = 0;
          nx[i].q1 = bus_if.issue_q1; nx[i].v1 = bus_if.issue_v1;
          nx[i].q2 = bus_if.issue_q2; nx[i].v2 = bus_if.issue_v2;
          capture(nx[i].q1, nx[i].v1, m_addbus, bus_if.multbus, bus_if.loadbus);
          capture(nx[i].q2, nx[i].v2, m_addbus, bus_if.multbus, bus_if.loadbus);
          done = 1;
        end
      end
    end
    for (int i = 0; i < ENTRIES; i++) m[i] = nx[i];
    m_addbus = bc;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        logic       exp_rdy;
        logic [7:0] exp_tag;
        exp_rdy = 0;
        exp_tag = 8'h00;
        for (int i = ENTRIES - 1; i >= 0; i--)
          if (!m[i].busy) begin exp_rdy = 1; exp_tag = TAG_BASE + 8'(i); end
        chk("model_addbus", bus_if.addbus, m_addbus);
        chk("model_issue_ready", {39'h0, bus_if.issue_ready}, {39'h0, exp_rdy});
        chk("model_issue_tag", {32'h0, bus_if.issue_tag}, {32'h0, exp_tag});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change just after the falling edge
  // --------------------------------------------------------------------------
  task automatic issue(input logic [7:0] q1, input logic [31:0] v1,
                       input logic [7:0] q2, input logic [31:0] v2);
    bus_if.issue_valid = 1'b1;
    bus_if.issue_q1 = q1; bus_if.issue_v1 = v1;
    bus_if.issue_q2 = q2; bus_if.issue_v2 = v2;
    @(negedge clk);
    bus_if.issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_q1 = 8'h00; bus_if.issue_v1 = 32'h0;
    bus_if.issue_q2 = 8'h00; bus_if.issue_v2 = 32'h0;
    bus_if.loadbus = 40'h0;
    bus_if.multbus = 40'h0;
    #1;
    chk("reset_addbus", bus_if.addbus, 40'h0);
    chk("reset_issue_ready", {39'h0, bus_if.issue_ready}, 40'h1);
    chk("reset_issue_tag", {32'h0, bus_if.issue_tag}, 40'h20);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Both operands valid: 5 + 7
    chk("t1_tag_before_accept", {32'h0, bus_if.issue_tag}, 40'h20);
    issue(8'h00, 32'd5, 8'h00, 32'd7);
    idle(2);
    chk("t1_result", bus_if.addbus, 40'h20_0000000C);
    idle(1);
    chk("t1_idle_after", bus_if.addbus, 40'h0);
    idle(2);

    // Operand from multbus
    issue(8'h30, 32'hDEADBEEF, 8'h00, 32'd1);
    bus_if.multbus = 40'h30_00000009;
    @(negedge clk);
    bus_if.multbus = 40'h0;
    idle(2);
    chk("t2_mult_capture", bus_if.addbus, 40'h20_0000000A);
    idle(3);

    // Bypass from loadbus in the accept cycle
    bus_if.loadbus = 40'h40_00000003;
    issue(8'h40, 32'h0, 8'h00, 32'd4);
    bus_if.loadbus = 40'h0;
    idle(2);
    chk("t3_bypass", bus_if.addbus, 40'h20_00000007);
    idle(3);

    // Fill all entries waiting on 8'h31
    issue(8'h31, 32'h0, 8'h00, 32'd1);
    issue(8'h31, 32'h0, 8'h00, 32'd2);
    issue(8'h31, 32'h0, 8'h00, 32'd3);
    chk("t4_full_ready", {39'h0, bus_if.issue_ready}, 40'h0);
    chk("t4_full_tag", {32'h0, bus_if.issue_tag}, 40'h0);
    issue(8'h00, 32'd100, 8'h00, 32'd0);
    bus_if.multbus = 40'h31_00000010;
    @(negedge clk);
    bus_if.multbus = 40'h0;
    idle(2);
    chk("t4_a0", bus_if.addbus, 40'h20_00000011);
    chk("t4_ready_back", {39'h0, bus_if.issue_ready}, 40'h1);
    chk("t4_tag_back", {32'h0, bus_if.issue_tag}, 40'h20);
    idle(1);
    chk("t4_a1", bus_if.addbus, 40'h21_00000012);
    idle(1);
    chk("t4_a2", bus_if.addbus, 40'h22_00000013);
    idle(3);

    // Chain through own addbus
    issue(8'h00, 32'd1, 8'h00, 32'd2);
    issue(8'h20, 32'h0, 8'h00, 32'd10);
    idle(1);
    chk("t5_first", bus_if.addbus, 40'h20_00000003);
    idle(3);
    chk("t5_chained", bus_if.addbus, 40'h21_0000000D);
    idle(2);

    // Wrap-around
    issue(8'h00, 32'hFFFFFFFF, 8'h00, 32'd2);
    idle(2);
    chk("t5_wrap", bus_if.addbus, 40'h20_00000001);
    idle(3);

    // Reset while an op sits in the execute stage
    issue(8'h00, 32'd3, 8'h00, 32'd4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_addbus", bus_if.addbus, 40'h0);
    chk("t6_rst_ready", {39'h0, bus_if.issue_ready}, 40'h1);
    chk("t6_rst_tag", {32'h0, bus_if.issue_tag}, 40'h20);
    idle(2);
    rst = 1'b0;
    idle(4);
    chk("t6_no_late_result", bus_if.addbus, 40'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
